sa_job_scheduler: RTL
=====================

# sa_job_scheduler

- Shares one `systolic_array` instance between NUM_REQ independent job requesters.
- Each job is one pair of N-wide operand vectors (A row, B column).
- Accepts jobs through per-requester valid/ready handshakes and picks a winner round-robin.
- Issues the winner's operands to the array as a single-cycle `in_valid` pulse, holds off further issues until the array is quiescent, and routes the array's serialized result beats back to the job owner.

## Interface
- DIN_WIDTH, 8: operand width; must match the array.
- N, 2: array dimension; N >= 2.
- NUM_REQ, 2: number of requesters; NUM_REQ >= 2.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  [NUM_REQ]  requester r has a job.
- req_ready  out  [NUM_REQ]  job accepted; one-hot or zero.
- req_a  in  [NUM_REQ][N] x DIN_WIDTH  A operands per requester.
- req_b  in  [NUM_REQ][N] x DIN_WIDTH  B operands per requester.
- arr_a_din  out  [N] x DIN_WIDTH  to array `a_din`.
- arr_b_din  out  [N] x DIN_WIDTH  to array `b_din`.
- arr_in_valid  out  1  to array `in_valid`.
- arr_c_out  in  2*DIN_WIDTH  from array `c_out`.
- arr_out_valid  in  1  from array `out_valid`.
- arr_out_idx  in  $clog2(N)  from array `out_idx`.
- rsp_valid  out  [NUM_REQ]  one-hot result beat for the owner.
- rsp_data  out  2*DIN_WIDTH  result value.
- rsp_idx  out  $clog2(N)  result row index.
- busy  out  1  a job is in flight.

## Operation
- FSM states: IDLE, ISSUE, BUSY. Reset state is IDLE.
- **IDLE**
  - Round-robin arbitration over req_valid; the search starts at the requester after the last winner. The pointer resets to 0, so requester 0 wins first.
  - req_ready is combinational: high only for the winner, only in IDLE.
  - On handshake: latch req_a/req_b into arr_a_din/arr_b_din, latch the owner id, advance the pointer, go to ISSUE.
- **ISSUE**
  - arr_in_valid = 1 for exactly this cycle; go to BUSY with cnt = 2N.
- **BUSY**
  - Decrement cnt each cycle; go to IDLE after cnt reaches 0. BUSY lasts 2N+1 cycles.
- **Response routing**
  - Every arr_out_valid beat seen in ISSUE or BUSY is registered to rsp_valid[owner]=1, with rsp_data=arr_c_out and rsp_idx=arr_out_idx.
  - Beats are forwarded as received. The scheduler does not count them, and completion is purely time-based.
  - Beats arriving in IDLE are dropped.
- **Requester rule**: req_valid and payload must stay stable until req_ready. The scheduler holds no per-requester queue.
- busy = (state != IDLE).

## Timing
- Reset values: req_ready=0, arr_in_valid=0, arr_a_din=arr_b_din=0, rsp_valid=0, rsp_data=0, rsp_idx=0, busy=0, owner=0, pointer=0.
- Handshake at cycle t gives arr_in_valid at t+1 and BUSY for cycles t+2..t+2N+2.
- The earliest next handshake is t+2N+3 and the earliest next issue is t+2N+4. The per-job issue interval is therefore 2N+3 cycles.
- Array beat visible at cycle c gives rsp_valid at c+1. The last beat of a job reaches the owner before the owner register can change.
- Simultaneous requests: exactly one is granted; losers keep waiting and are served in round-robin order. No requester waits more than NUM_REQ-1 jobs.
- Reset mid-job: everything returns to reset values at once and the in-flight job is lost. The array shares rst_n.

## Configuration
- SA_SCHED_PERF_EN defined:
  - Adds outputs perf_jobs [NUM_REQ] x 16 (saturating count of accepted jobs per requester) and perf_busy 32-bit (wrapping count of cycles with busy=1).
  - Both counters reset to 0.
- SA_SCHED_PERF_EN undefined: these ports and their logic are absent, and all other behaviour is identical.

## Structure
- Shared package sa_sched_pkg holds:
  - state enum (IDLE/ISSUE/BUSY);
  - function busy_cycles(N) = 2N+1;
  - perf counter widths.
- One sub-module, sa_rr_arbiter: NUM_REQ-wide round-robin arbiter.
  - Inputs: req, advance.
  - Outputs: one-hot grant and winner id.

## Test plan
- Single job, N=2, req 0, A={1,2}, B={3,4} -> req_ready[0] at t, arr_in_valid only at t+1, busy high for t+1..t+6, every array beat mirrored on rsp_valid[0] one cycle later.
- req_valid=2'b11 held for 4 jobs -> grant order 0,1,0,1; handshakes exactly 7 cycles apart (N=2).
- Request raised during BUSY -> req_ready stays 0 until IDLE, then granted in the first IDLE cycle.
- Injected arr_out_valid while IDLE -> no rsp_valid.
- rst_n dropped mid-BUSY -> all outputs at reset values immediately; the next job after reset goes to requester 0.
- With SA_SCHED_PERF_EN, 3 jobs from req 1 and 1 from req 0 -> perf_jobs={1,3}, perf_busy=4*(2N+2)=24 for N=2.

Source files
------------

// File: rtl/sa_sched_pkg.sv
// Shared types and constants for the systolic-array job scheduler.
package sa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } sched_state_e;

  localparam int unsigned PERF_JOB_W  = 16;
  localparam int unsigned PERF_BUSY_W = 32;

  // Cycles spent in BUSY after an issue, long enough to drain an N x N array.
  function automatic int unsigned busy_cycles(input int unsigned n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/sa_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and moves on advance.
module sa_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDW-1:0]     winner_c
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] idx;
  logic           found;

  // Scan from lowest to highest priority so the requester nearest ptr_q wins last.
  always_comb begin
    grant_c  = '0;
    found    = 1'b0;
    idx      = '0;
    winner_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((32'(ptr_q) + NUM_REQ - 1 - i) % NUM_REQ);
      if (req[idx]) begin
        found    = 1'b1;
        winner_c = idx;
      end
    end
    grant_c = found ? (NUM_REQ'(1) << winner_c) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (32'(winner_c) == NUM_REQ - 1) ? '0 : IDW'(32'(winner_c) + 1);
    end
  end

endmodule

// File: rtl/sa_job_scheduler.sv
// Shares one systolic_array between NUM_REQ requesters: round-robin job accept, single-cycle
// issue, time-based completion and result routing. SA_SCHED_PERF_EN adds perf counters.
module sa_job_scheduler
  import sa_sched_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = 8,
  parameter int unsigned N         = 2,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ-1:0][N-1:0][DIN_WIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0][N-1:0][DIN_WIDTH-1:0] req_b,
  output logic [N-1:0][DIN_WIDTH-1:0]              arr_a_din,
  output logic [N-1:0][DIN_WIDTH-1:0]              arr_b_din,
  output logic                                     arr_in_valid,
  input  logic [2*DIN_WIDTH-1:0]                   arr_c_out,
  input  logic                                     arr_out_valid,
  input  logic [$clog2(N)-1:0]                     arr_out_idx,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  output logic [2*DIN_WIDTH-1:0]                   rsp_data,
  output logic [$clog2(N)-1:0]                     rsp_idx,
  output logic                                     busy
`ifdef SA_SCHED_PERF_EN
  ,
  output logic [NUM_REQ-1:0][PERF_JOB_W-1:0]       perf_jobs,
  output logic [PERF_BUSY_W-1:0]                   perf_busy
`endif
);

  localparam int unsigned IDW   = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(busy_cycles(N));

  sched_state_e       state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [IDW-1:0]     owner_q;
  logic [NUM_REQ-1:0] grant_c;
  logic [IDW-1:0]     winner_c;
  logic               handshake_c;

  sa_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (handshake_c),
    .grant_c  (grant_c),
    .winner_c (winner_c)
  );

  // Next-state logic; req_ready is a combinational grant, forced low while in reset.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    req_ready   = '0;
    handshake_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst_n ? grant_c : '0;
        if (rst_n && (|grant_c)) begin
          handshake_c = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = CNT_W'(busy_cycles(N) - 1);
        state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Operand capture, issue strobe and owner tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_a_din    <= '0;
      arr_b_din    <= '0;
      arr_in_valid <= 1'b0;
      owner_q      <= '0;
      busy         <= 1'b0;
    end else begin
      arr_in_valid <= handshake_c;
      busy         <= (state_nxt != IDLE);
      if (handshake_c) begin
        arr_a_din <= req_a[winner_c];
        arr_b_din <= req_b[winner_c];
        owner_q   <= winner_c;
      end
    end
  end

  // Result beats are forwarded to the job owner; beats seen while idle belong to nobody.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_idx   <= '0;
    end else begin
      rsp_valid <= '0;
      if (arr_out_valid && (state_q != IDLE)) begin
        rsp_valid <= NUM_REQ'(1) << owner_q;
        rsp_data  <= arr_c_out;
        rsp_idx   <= arr_out_idx;
      end
    end
  end

`ifdef SA_SCHED_PERF_EN
  // Saturating per-requester job counts and a wrapping busy-cycle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else begin
      perf_busy <= perf_busy + PERF_BUSY_W'(busy);
      if (handshake_c && (perf_jobs[winner_c] != '1)) begin
        perf_jobs[winner_c] <= perf_jobs[winner_c] + PERF_JOB_W'(1);
      end
    end
  end
`endif

endmodule
